// File: rtl/imm_gen_pipe.sv
`default_nettype none
// imm_gen_pipe -- RV32I/RV64I immediate decoder feeding a DEPTH-entry in-order result FIFO.
// Rev 1.0
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 8,
  parameter bit NEG_SUBI_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              inst_code,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          Imm_out,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  logic [6:0]         opc;
  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;
  logic               neg_subi;
  logic [XLEN-1:0]    dec_imm;
  fmt_e               dec_fmt;
  logic               dec_ill;

  assign opc   = inst_code[6:0];
  assign i_imm = inst_code[31:20];
  assign s_imm = {inst_code[31:25], inst_code[11:7]};
  assign b_imm = {inst_code[31], inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0};
  assign u_imm = {inst_code[31:12], 12'b0};
  assign j_imm = {inst_code[31], inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0};

  assign neg_subi = NEG_SUBI_EN && (opc == 7'b0010011) &&
                    (inst_code[31:25] == 7'b0100000) && (inst_code[14:12] == 3'b000);

  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_imm = XLEN'(i_imm);
        dec_fmt = FMT_I;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_imm = XLEN'(i_imm);
          dec_fmt = FMT_I;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_imm = XLEN'(s_imm);
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        dec_imm = XLEN'(b_imm);
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = XLEN'(u_imm);
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        dec_imm = XLEN'(j_imm);
        dec_fmt = FMT_J;
      end
      default: dec_ill = 1'b1;
    endcase
    if (neg_subi) dec_imm = -dec_imm;
  end

  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [2:0]       fmt_q [DEPTH];
  logic             ill_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    head;
  logic             push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        imm_q[wr_ptr_q] <= dec_imm;
        fmt_q[wr_ptr_q] <= dec_fmt;
        ill_q[wr_ptr_q] <= dec_ill;
        tag_q[wr_ptr_q] <= in_tag;
      end
    end
  end

  // When empty, point at the slot just popped so the outputs hold their last value.
  assign head        = (count_q == '0) ? rd_ptr_q - AW'(1) : rd_ptr_q;
  assign Imm_out     = imm_q[head];
  assign out_fmt     = fmt_q[head];
  assign out_illegal = ill_q[head];
  assign out_tag     = tag_q[head];
  assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// tb_imm_gen_pipe -- table-driven scoreboard bench; DUT A is XLEN=32/NEG on, DUT B is XLEN=64/NEG off.
// Rev 1.0
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst_code;
  logic [7:0]  in_tag;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [7:0]  tag_a;
  logic [2:0]  count_a;

  logic        in_ready_b, out_valid_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [7:0]  tag_b;
  logic [2:0]  count_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(8), .NEG_SUBI_EN(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .Imm_out(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a), .out_tag(tag_a), .count(count_a)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(8), .NEG_SUBI_EN(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .Imm_out(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b), .out_tag(tag_b), .count(count_b)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [7:0] tag;
  } exp_t;

  localparam int NV = 15;
  vec_t       tbl [NV];
  exp_t       sb [$];
  exp_t       last;
  int         checks = 0;
  int         errors = 0;
  int         cur_idx = 0;
  bit         pushed;
  logic [7:0] tag_ctr = 8'h10;

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] i32, input logic [2:0] f32,
                              input logic l32, input logic [63:0] i64, input logic [2:0] f64,
                              input logic l64);
    vec_t r;
    r.inst = inst; r.imm32 = i32; r.fmt32 = f32; r.ill32 = l32;
    r.imm64 = i64; r.fmt64 = f64; r.ill64 = l64;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called just after a negedge: checks state, updates the scoreboard, advances one clock.
  task automatic cycle();
    bit   do_push, do_pop;
    exp_t e;
    #1;
    chk("count_a", 64'(count_a), 64'(sb.size()));
    chk("count_b", 64'(count_b), 64'(sb.size()));
    chk("out_valid_a", 64'(out_valid_a), 64'(sb.size() != 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(sb.size() != 0));
    chk("in_ready_a", 64'(in_ready_a), 64'(sb.size() != 4));
    chk("in_ready_b", 64'(in_ready_b), 64'(sb.size() != 4));
    do_push = in_valid && (sb.size() != 4);
    do_pop  = out_ready && (sb.size() != 0);
    if (do_pop) begin
      e = sb.pop_front();
      chk("imm_a", 64'(imm_a), 64'(e.v.imm32));
      chk("fmt_a", 64'(fmt_a), 64'(e.v.fmt32));
      chk("ill_a", 64'(ill_a), 64'(e.v.ill32));
      chk("tag_a", 64'(tag_a), 64'(e.tag));
      chk("imm_b", imm_b, e.v.imm64);
      chk("fmt_b", 64'(fmt_b), 64'(e.v.fmt64));
      chk("ill_b", 64'(ill_b), 64'(e.v.ill64));
      chk("tag_b", 64'(tag_b), 64'(e.tag));
      last = e;
    end
    if (do_push) begin
      e.v   = tbl[cur_idx];
      e.tag = in_tag;
      sb.push_back(e);
    end
    pushed = do_push;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input int idx);
    cur_idx   = idx;
    inst_code = tbl[idx].inst;
    in_tag    = tag_ctr;
    in_valid  = 1'b1;
  endtask

  task automatic push_item(input int idx);
    set_in(idx);
    pushed = 1'b0;
    for (int k = 0; k < 20 && !pushed; k++) cycle();
    if (!pushed) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: item %0d not accepted within 20 cycles", idx);
    end
    tag_ctr++;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", sb.size());
    end
    cycle();
  endtask

  initial begin
    tbl[0]  = mk(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    tbl[1]  = mk(32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    tbl[2]  = mk(32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    tbl[3]  = mk(32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0);
    tbl[4]  = mk(32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0);
    tbl[5]  = mk(32'h00000033, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1);
    tbl[6]  = mk(32'h40500093, 32'hFFFFFBFB, 3'd1, 1'b0, 64'h0000000000000405, 3'd1, 1'b0);
    tbl[7]  = mk(32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    tbl[8]  = mk(32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0);
    tbl[9]  = mk(32'h00402083, 32'h00000004, 3'd1, 1'b0, 64'h0000000000000004, 3'd1, 1'b0);
    tbl[10] = mk(32'hFFC08067, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
    tbl[11] = mk(32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0);
    tbl[12] = mk(32'hFF9FF06F, 32'hFFFFFFF8, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0);
    tbl[13] = mk(32'h40501093, 32'h00000405, 3'd1, 1'b0, 64'h0000000000000405, 3'd1, 1'b0);
    tbl[14] = mk(32'h40000093, 32'hFFFFFC00, 3'd1, 1'b0, 64'h0000000000000400, 3'd1, 1'b0);

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst_code = 32'h0;
    in_tag    = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_count_a", 64'(count_a), 64'd0);
    chk("rst_valid_a", 64'(out_valid_a), 64'd0);
    chk("rst_ready_a", 64'(in_ready_a), 64'd1);
    chk("rst_imm_a", 64'(imm_a), 64'd0);
    chk("rst_fmt_a", 64'(fmt_a), 64'd0);
    chk("rst_ill_a", 64'(ill_a), 64'd0);
    chk("rst_tag_a", 64'(tag_a), 64'd0);
    chk("rst_imm_b", imm_b, 64'd0);
    reset = 1'b0;

    // Back-to-back decode of every vector with a free-running consumer.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) push_item(i);
    drain();
    chk("hold_imm_a", 64'(imm_a), 64'(last.v.imm32));
    chk("hold_tag_a", 64'(tag_a), 64'(last.tag));
    chk("hold_imm_b", imm_b, last.v.imm64);

    // Fill to DEPTH with the consumer stalled, hold the 5th, then stream through the wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_item(i);
    set_in(4);
    repeat (3) cycle();
    out_ready = 1'b1;
    for (int i = 4; i < 12; i++) push_item(i);
    drain();

    // Asynchronous reset with entries in flight.
    out_ready = 1'b0;
    for (int i = 9; i < 12; i++) push_item(i);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_valid_a", 64'(out_valid_a), 64'd0);
    chk("arst_count_a", 64'(count_a), 64'd0);
    chk("arst_ready_a", 64'(in_ready_a), 64'd1);
    chk("arst_valid_b", 64'(out_valid_b), 64'd0);
    chk("arst_imm_a", 64'(imm_a), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    push_item(3);
    push_item(7);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
